// File: rtl/cursor_update_ctrl_pkg.sv
// Shared types, widths and playfield defaults for the cursor position datapath.
// Also used by the pixel-overlay block so both agree on bounds and reset position.
// Holds the clamp-and-step helper used when computing the next coordinate.
package cursor_update_ctrl_pkg;

  localparam int COORD_W = 10;
  localparam int G_W     = 10;
  localparam int VCNT_W  = 11;

  localparam int DEF_X_MIN    = 0;
  localparam int DEF_X_MAX    = 634;
  localparam int DEF_Y_MIN    = 0;
  localparam int DEF_Y_MAX    = 475;
  localparam int DEF_X_RESET  = 300;
  localparam int DEF_Y_RESET  = 300;
  localparam int DEF_V_COMMIT = 481;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_REQ        = 3'd1,
    ST_CALC       = 3'd2,
    ST_WAIT_FRAME = 3'd3,
    ST_COMMIT     = 3'd4
  } state_t;

  // New coordinate = current + (tilt >>> shift), saturated to [lo, hi].
  // 12-bit signed arithmetic covers 0..1023 plus a delta of at most +/-512.
  function automatic logic [COORD_W-1:0] step_clamp(
    input logic [COORD_W-1:0] cur,
    input logic [G_W-1:0]     g,
    input int                 shift,
    input int                 lo,
    input int                 hi
  );
    logic signed [11:0] dx;
    logic signed [11:0] sum;
    dx  = $signed({{(12-G_W){g[G_W-1]}}, g}) >>> shift;
    sum = $signed({{(12-COORD_W){1'b0}}, cur}) + dx;
    if (sum < $signed(12'(lo)))
      return COORD_W'(lo);
    else if (sum > $signed(12'(hi)))
      return COORD_W'(hi);
    else
      return sum[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/cursor_update_ctrl_tick_gen.sv
// Free-running divider producing a single-cycle update enable every TICK_DIV clocks.
// Latency: tick is high while the counter holds TICK_DIV-1 (combinational decode).
// No backpressure: the counter never stalls; consumers drop ticks they cannot take.
module cursor_update_ctrl_tick_gen #(
  parameter int TICK_DIV = 10000000
) (
  input  logic CLK,
  input  logic RST,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(TICK_DIV - 1));
  assign tick   = w_wrap;

  // Counter 0..TICK_DIV-1, wrapping; runs in every controller state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      r_cnt <= '0;
    else if (w_wrap)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + CW'(1);
  end

endmodule

// File: rtl/cursor_update_ctrl.sv
// Per tick: fetch one tilt sample, compute clamped position, commit it in vertical blank.
// Latency: handshake -> coordinate change is 3 cycles plus the wait for V_COMMIT.
// Backpressure: waits indefinitely for sample_valid; ticks arriving while busy set overrun.
module cursor_update_ctrl
  import cursor_update_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 10000000,
  parameter int SHIFT    = 3,
  parameter int X_MIN    = DEF_X_MIN,
  parameter int X_MAX    = DEF_X_MAX,
  parameter int Y_MIN    = DEF_Y_MIN,
  parameter int Y_MAX    = DEF_Y_MAX,
  parameter int X_RESET  = DEF_X_RESET,
  parameter int Y_RESET  = DEF_Y_RESET,
  parameter int V_COMMIT = DEF_V_COMMIT
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [G_W-1:0]     xAxisG,
  input  logic [G_W-1:0]     yAxisG,
  input  logic               sample_valid,
  output logic               sample_ready,
  input  logic [VCNT_W-1:0]  vga_vcounter,
  output logic [COORD_W-1:0] xCoord,
  output logic [COORD_W-1:0] yCoord,
  output logic               coord_update,
  output logic               busy,
  output logic               overrun
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_tick;
  logic                 w_hs;
  logic                 w_vmatch;
  logic [G_W-1:0]       r_x_smp;
  logic [G_W-1:0]       r_y_smp;
  logic [COORD_W-1:0]   r_x_nxt;
  logic [COORD_W-1:0]   r_y_nxt;
  logic [COORD_W-1:0]   r_x;
  logic [COORD_W-1:0]   r_y;
  logic                 r_coord_update;
  logic                 r_overrun;

  cursor_update_ctrl_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .CLK  (CLK),
    .RST  (RST),
    .tick (w_tick)
  );

  assign w_hs     = sample_valid && (r_state == ST_REQ);
  assign w_vmatch = (vga_vcounter == VCNT_W'(V_COMMIT));

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Next-state: one pass IDLE->REQ->CALC->WAIT_FRAME->COMMIT->IDLE per accepted tick.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:       if (w_tick)   w_state_nxt = ST_REQ;
      ST_REQ:        if (w_hs)     w_state_nxt = ST_CALC;
      ST_CALC:                     w_state_nxt = ST_WAIT_FRAME;
      ST_WAIT_FRAME: if (w_vmatch) w_state_nxt = ST_COMMIT;
      ST_COMMIT:                   w_state_nxt = ST_IDLE;
      default:                     w_state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    sample_ready = (r_state == ST_REQ);
    busy         = (r_state != ST_IDLE);
  end

  // Datapath: capture sample, compute clamped target, commit on leaving COMMIT.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_x_smp        <= '0;
      r_y_smp        <= '0;
      r_x_nxt        <= '0;
      r_y_nxt        <= '0;
      r_x            <= COORD_W'(X_RESET);
      r_y            <= COORD_W'(Y_RESET);
      r_coord_update <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_coord_update <= (r_state == ST_COMMIT);
      // Ticks are only consumed in IDLE; anything else (including COMMIT) loses one.
      if (w_tick && (r_state != ST_IDLE))
        r_overrun <= 1'b1;
      if (w_hs) begin
        r_x_smp <= xAxisG;
        r_y_smp <= yAxisG;
      end
      if (r_state == ST_CALC) begin
        r_x_nxt <= step_clamp(r_x, r_x_smp, SHIFT, X_MIN, X_MAX);
        r_y_nxt <= step_clamp(r_y, r_y_smp, SHIFT, Y_MIN, Y_MAX);
      end
      if (r_state == ST_COMMIT) begin
        r_x <= r_x_nxt;
        r_y <= r_y_nxt;
      end
    end
  end

  assign xCoord       = r_x;
  assign yCoord       = r_y;
  assign coord_update = r_coord_update;
  assign overrun      = r_overrun;

endmodule

// File: doc/cursor_update_ctrl.md
Name: cursor_update_ctrl

Overview:
- Sequences the cursor/ball position datapath: requests one accelerometer sample per update tick, converts tilt to a signed pixel delta, clamps to the playfield, and commits the new coordinates only at a frame boundary.
- Sits between the accelerometer front end and the VGA pixel-overlay logic; its xCoord/yCoord outputs feed the overlay's pixel comparators.
- Replaces the divided-clock update scheme: everything runs on CLK with a one-cycle tick enable.

Parameters:
- TICK_DIV, 10000000, CLK cycles per update tick (>= 2)
- SHIFT, 3, arithmetic right-shift applied to the raw G value to form the delta
- X_MIN, 0, lowest legal xCoord
- X_MAX, 634, highest legal xCoord (640 minus 6-pixel cursor width)
- Y_MIN, 0, lowest legal yCoord
- Y_MAX, 475, highest legal yCoord
- X_RESET, 300, xCoord after reset
- Y_RESET, 300, yCoord after reset
- V_COMMIT, 481, vga_vcounter value (inside vertical blank) at which the commit is allowed

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, asynchronous, active-low
- xAxisG  in  10  X tilt, two's complement
- yAxisG  in  10  Y tilt, two's complement
- sample_valid  in  1  xAxisG/yAxisG valid
- sample_ready  out  1  controller accepts a sample this cycle
- vga_vcounter  in  11  current VGA line
- xCoord  out  10  committed X position
- yCoord  out  10  committed Y position
- coord_update  out  1  one-cycle pulse on the cycle the coordinates change
- busy  out  1  FSM not in IDLE
- overrun  out  1  sticky: a tick arrived while not IDLE

Behaviour:
- Reset (RST=0, async):
  - xCoord=X_RESET, yCoord=Y_RESET.
  - State IDLE; tick counter 0.
  - sample_ready, coord_update, busy and overrun are 0.
  - Internal sample and next-position registers are cleared.
  - Reset asserted mid-operation abandons any pending update; no partial commit occurs.
- Tick generator:
  - Counter runs 0..TICK_DIV-1, then wraps to 0.
  - tick is high for one cycle when the counter equals TICK_DIV-1.
  - The counter runs freely in every state.
- FSM states: IDLE, REQ, CALC, WAIT_FRAME, COMMIT.
  - IDLE: on tick -> REQ.
  - REQ: sample_ready=1. When sample_valid & sample_ready, capture xAxisG/yAxisG -> CALC. There is no timeout; the FSM waits indefinitely.
  - CALC (1 cycle):
    - dx = sign-extended xAxisG arithmetically shifted right by SHIFT (rounds toward -inf, so -1 gives -1).
    - sum = zero-extended xCoord + dx, computed in 12-bit signed.
    - If sum < X_MIN, next = X_MIN; if sum > X_MAX, next = X_MAX; otherwise next = sum[9:0]. Y is handled identically.
    - Then -> WAIT_FRAME.
  - WAIT_FRAME: when vga_vcounter == V_COMMIT -> COMMIT. If the match is already true on entry, advance on that cycle.
  - COMMIT (1 cycle):
    - xCoord/yCoord load next on the clock edge leaving COMMIT; coord_update is high for the following single cycle, coincident with the new values.
    - Then -> IDLE. COMMIT always returns to IDLE, even if vga_vcounter still equals V_COMMIT; a second commit needs a new tick.
- Timing: latency from sample handshake to coordinate change is at least 3 cycles (CALC, WAIT_FRAME, COMMIT) plus the wait for V_COMMIT.
- busy = (state != IDLE).
- Overrun:
  - A tick seen in any state other than IDLE is dropped and sets overrun; only reset clears overrun.
  - A tick in the same cycle as the COMMIT->IDLE transition is also dropped.
- Coordinates never wrap: the clamp guarantees X_MIN <= xCoord <= X_MAX and Y_MIN <= yCoord <= Y_MAX at all times.
- Values of xAxisG/yAxisG outside the handshake cycle are ignored.

Decomposition:
- Shared package holds:
  - the state enum
  - COORD_W=10, G_W=10, VCNT_W=11
  - the default bounds and reset coordinates, shared with the pixel-overlay block.
- One sub-module, tick_gen: parameter TICK_DIV, ports CLK and RST, output tick (single-cycle enable pulse). It is a clock enable, not a derived clock.

Test Plan:
- Reset release -> xCoord=300, yCoord=300, coord_update=0, busy=0, overrun=0; with TICK_DIV=8, sample_ready rises 8 cycles after reset release.
- TICK_DIV=8, xAxisG=10'h050 (+80), yAxisG=10'h000, V_COMMIT reached immediately -> xCoord=310, yCoord=300, with one coord_update pulse.
- xAxisG=10'h3B0 (-80), yAxisG=10'h3FF (-1) -> xCoord=290, yCoord=299 (the -1 rounds to -1).
- Start from xCoord=630 and apply xAxisG=10'h1FF (+511, delta +63) -> xCoord=634. Then yCoord=2 with yAxisG=10'h200 (-512, delta -64) -> yCoord=0.
- Hold vga_vcounter at 100 for 50 cycles after CALC -> coordinates unchanged and busy=1; set vcounter=481 -> update appears 2 cycles later.
- Hold sample_valid=0 for 3 tick periods -> overrun=1 and busy stays 1; then valid -> exactly one update. Assert RST low during WAIT_FRAME -> outputs return to reset values at once and no coord_update occurs.
